// File: rtl/threshold_pkg.sv
// rtl/threshold_pkg.sv - shared threshold addresses, defaults and controller state encoding
package threshold_pkg;

    localparam logic [2:0] ADDR_Y_TH  = 3'd0;
    localparam logic [2:0] ADDR_Y_TL  = 3'd1;
    localparam logic [2:0] ADDR_CB_TH = 3'd2;
    localparam logic [2:0] ADDR_CB_TL = 3'd3;
    localparam logic [2:0] ADDR_CR_TH = 3'd4;
    localparam logic [2:0] ADDR_CR_TL = 3'd5;

    localparam logic [7:0] DEF_Y_TH  = 8'd93;
    localparam logic [7:0] DEF_Y_TL  = 8'd0;
    localparam logic [7:0] DEF_CB_TH = 8'd160;
    localparam logic [7:0] DEF_CB_TL = 8'd50;
    localparam logic [7:0] DEF_CR_TH = 8'd160;
    localparam logic [7:0] DEF_CR_TL = 8'd50;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHECK   = 2'd1,
        ST_PENDING = 2'd2
    } cfg_state_t;

    // A threshold set is usable only if every lower bound sits at or below its upper bound
    function automatic logic th_set_ok(
        input logic [7:0] y_th,  input logic [7:0] y_tl,
        input logic [7:0] cb_th, input logic [7:0] cb_tl,
        input logic [7:0] cr_th, input logic [7:0] cr_tl
    );
        return (y_tl <= y_th) && (cb_tl <= cb_th) && (cr_tl <= cr_th);
    endfunction

endpackage

// File: rtl/frame_fg_stat.sv
// rtl/frame_fg_stat.sv - frame edge detect and per-frame foreground pixel statistics
module frame_fg_stat #(
    parameter logic VS_POL = 1'b1,
    parameter int   CNT_W  = 21
) (
    input  logic             pixelclk,
    input  logic             reset_n,
    input  logic             i_vsync,
    input  logic             i_de,
    input  logic             i_fg,
    output logic             vs_edge,
    output logic [CNT_W-1:0] o_fg_count,
    output logic             o_fg_valid,
    output logic [15:0]      o_frame_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             vs_d;
    logic             first_seen;
    logic [CNT_W-1:0] pix_cnt;
    logic             pix_hit;

    assign pix_hit = i_de && i_fg;
    assign vs_edge = (i_vsync == VS_POL) && (vs_d != VS_POL);

    // Delay vsync by one cycle to find the start of its active level
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) vs_d <= !VS_POL;
        else          vs_d <= i_vsync;
    end

    // Saturating foreground counter; a hit on the edge cycle belongs to the new frame
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            pix_cnt <= '0;
        end else if (vs_edge) begin
            pix_cnt <= {{(CNT_W-1){1'b0}}, pix_hit};
        end else if (pix_hit && (pix_cnt != CNT_MAX)) begin
            pix_cnt <= pix_cnt + 1'b1;
        end
    end

    // Publish the finished frame's count, skipping the partial frame after reset
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            o_fg_count  <= '0;
            o_fg_valid  <= 1'b0;
            o_frame_cnt <= '0;
            first_seen  <= 1'b0;
        end else begin
            o_fg_valid <= 1'b0;
            if (vs_edge) begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
                first_seen  <= 1'b1;
                if (first_seen) begin
                    o_fg_count <= pix_cnt;
                    o_fg_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/threshold_cfg_ctrl.sv
// rtl/threshold_cfg_ctrl.sv - shadowed threshold registers applied atomically at frame boundaries
module threshold_cfg_ctrl
    import threshold_pkg::*;
#(
    parameter logic [7:0] Y_TH   = DEF_Y_TH,
    parameter logic [7:0] Y_TL   = DEF_Y_TL,
    parameter logic [7:0] CB_TH  = DEF_CB_TH,
    parameter logic [7:0] CB_TL  = DEF_CB_TL,
    parameter logic [7:0] CR_TH  = DEF_CR_TH,
    parameter logic [7:0] CR_TL  = DEF_CR_TL,
    parameter logic       VS_POL = 1'b1,
    parameter int         CNT_W  = 21
) (
    input  logic             pixelclk,
    input  logic             reset_n,
    input  logic             cfg_wr,
    input  logic [2:0]       cfg_addr,
    input  logic [7:0]       cfg_wdata,
    input  logic             cfg_commit,
    input  logic             i_vsync,
    input  logic             i_de,
    input  logic             i_fg,
    output logic [7:0]       o_y_th,
    output logic [7:0]       o_y_tl,
    output logic [7:0]       o_cb_th,
    output logic [7:0]       o_cb_tl,
    output logic [7:0]       o_cr_th,
    output logic [7:0]       o_cr_tl,
    output logic             o_pending,
    output logic             o_cfg_err,
    output logic [CNT_W-1:0] o_fg_count,
    output logic             o_fg_valid,
    output logic [15:0]      o_frame_cnt
);

    cfg_state_t state;
    logic [7:0] sh_y_th, sh_y_tl, sh_cb_th, sh_cb_tl, sh_cr_th, sh_cr_tl;
    logic       vs_edge;
    logic       addr_bad;

    assign addr_bad = cfg_wr && (cfg_addr > ADDR_CR_TL);

    frame_fg_stat #(
        .VS_POL (VS_POL),
        .CNT_W  (CNT_W)
    ) u_stat (
        .pixelclk    (pixelclk),
        .reset_n     (reset_n),
        .i_vsync     (i_vsync),
        .i_de        (i_de),
        .i_fg        (i_fg),
        .vs_edge     (vs_edge),
        .o_fg_count  (o_fg_count),
        .o_fg_valid  (o_fg_valid),
        .o_frame_cnt (o_frame_cnt)
    );

    // Shadow registers take software writes in every controller state
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            sh_y_th  <= Y_TH;
            sh_y_tl  <= Y_TL;
            sh_cb_th <= CB_TH;
            sh_cb_tl <= CB_TL;
            sh_cr_th <= CR_TH;
            sh_cr_tl <= CR_TL;
        end else if (cfg_wr) begin
            case (cfg_addr)
                ADDR_Y_TH:  sh_y_th  <= cfg_wdata;
                ADDR_Y_TL:  sh_y_tl  <= cfg_wdata;
                ADDR_CB_TH: sh_cb_th <= cfg_wdata;
                ADDR_CB_TL: sh_cb_tl <= cfg_wdata;
                ADDR_CR_TH: sh_cr_th <= cfg_wdata;
                ADDR_CR_TL: sh_cr_tl <= cfg_wdata;
                default:    ;
            endcase
        end
    end

    // Commit FSM: validate the shadow set, then copy it to the active set on a frame edge
    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            o_pending <= 1'b0;
            o_cfg_err <= 1'b0;
            o_y_th    <= Y_TH;
            o_y_tl    <= Y_TL;
            o_cb_th   <= CB_TH;
            o_cb_tl   <= CB_TL;
            o_cr_th   <= CR_TH;
            o_cr_tl   <= CR_TL;
        end else begin
            o_cfg_err <= addr_bad;
            case (state)
                ST_IDLE: begin
                    if (cfg_commit) state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (th_set_ok(sh_y_th, sh_y_tl, sh_cb_th, sh_cb_tl, sh_cr_th, sh_cr_tl)) begin
                        state     <= ST_PENDING;
                        o_pending <= 1'b1;
                    end else begin
                        state     <= ST_IDLE;
                        o_pending <= 1'b0;
                        o_cfg_err <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (vs_edge) begin
                        o_y_th    <= sh_y_th;
                        o_y_tl    <= sh_y_tl;
                        o_cb_th   <= sh_cb_th;
                        o_cb_tl   <= sh_cb_tl;
                        o_cr_th   <= sh_cr_th;
                        o_cr_tl   <= sh_cr_tl;
                        o_pending <= 1'b0;
                        state     <= cfg_commit ? ST_CHECK : ST_IDLE;
                    end else if (cfg_commit) begin
                        state <= ST_CHECK;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    o_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_threshold_cfg_ctrl.sv
// tb/tb_threshold_cfg_ctrl.sv - directed scoreboard bench for threshold_cfg_ctrl
module tb_threshold_cfg_ctrl;

    localparam int CNT_W = 21;

    logic             pixelclk = 1'b0;
    logic             reset_n  = 1'b0;
    logic             cfg_wr = 1'b0;
    logic [2:0]       cfg_addr = '0;
    logic [7:0]       cfg_wdata = '0;
    logic             cfg_commit = 1'b0;
    logic             i_vsync = 1'b0;
    logic             i_de = 1'b0;
    logic             i_fg = 1'b0;
    logic [7:0]       o_y_th, o_y_tl, o_cb_th, o_cb_tl, o_cr_th, o_cr_tl;
    logic             o_pending, o_cfg_err, o_fg_valid;
    logic [CNT_W-1:0] o_fg_count;
    logic [15:0]      o_frame_cnt;

    int checks = 0;
    int errors = 0;
    int frames = 0;
    int exp_q[$];

    always #5 pixelclk = ~pixelclk;

    threshold_cfg_ctrl #(.CNT_W(CNT_W)) dut (
        .pixelclk    (pixelclk),
        .reset_n     (reset_n),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_commit  (cfg_commit),
        .i_vsync     (i_vsync),
        .i_de        (i_de),
        .i_fg        (i_fg),
        .o_y_th      (o_y_th),
        .o_y_tl      (o_y_tl),
        .o_cb_th     (o_cb_th),
        .o_cb_tl     (o_cb_tl),
        .o_cr_th     (o_cr_th),
        .o_cr_tl     (o_cr_tl),
        .o_pending   (o_pending),
        .o_cfg_err   (o_cfg_err),
        .o_fg_count  (o_fg_count),
        .o_fg_valid  (o_fg_valid),
        .o_frame_cnt (o_frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pixelclk);
        #1;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [7:0] data);
        cfg_wr = 1'b1; cfg_addr = addr; cfg_wdata = data;
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
    endtask

    // One frame boundary; a report is expected only once a full frame has been seen
    task automatic frame_edge(input int exp_cnt, input bit report);
        if (report) exp_q.push_back(exp_cnt);
        i_vsync = 1'b1;
        step();
        frames++;
        chk("frame_cnt", 32'(o_frame_cnt), 32'(frames & 16'hffff));
        i_vsync = 1'b0;
        step();
    endtask

    // Scoreboard side: every o_fg_valid pulse must match the oldest queued frame count
    always begin
        @(posedge pixelclk);
        #1;
        if (reset_n && o_fg_valid) begin
            if (exp_q.size() == 0) chk("fg_valid_spurious", 32'd1, 32'd0);
            else chk("fg_count", 32'(o_fg_count), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_y_th", 32'(o_y_th), 93);
        chk("rst_y_tl", 32'(o_y_tl), 0);
        chk("rst_cb_th", 32'(o_cb_th), 160);
        chk("rst_cb_tl", 32'(o_cb_tl), 50);
        chk("rst_cr_th", 32'(o_cr_th), 160);
        chk("rst_cr_tl", 32'(o_cr_tl), 50);
        chk("rst_pending", 32'(o_pending), 0);
        chk("rst_frame_cnt", 32'(o_frame_cnt), 0);
        chk("rst_fg_valid", 32'(o_fg_valid), 0);
        chk("rst_cfg_err", 32'(o_cfg_err), 0);
        reset_n = 1'b1;
        step();
        frame_edge(0, 1'b0);

        // Valid commit mid-frame, applied at the next frame edge
        wr(3'd0, 8'd120);
        commit();
        chk("pend_after_commit", 32'(o_pending), 0);
        step();
        chk("pend_two_cycles", 32'(o_pending), 1);
        repeat (4) step();
        chk("y_th_held", 32'(o_y_th), 93);
        exp_q.push_back(0);
        i_vsync = 1'b1;
        step();
        frames++;
        chk("y_th_applied", 32'(o_y_th), 120);
        chk("pend_cleared", 32'(o_pending), 0);
        i_vsync = 1'b0;
        step();

        // Invalid set: CB_TL above CB_TH
        wr(3'd3, 8'd200);
        commit();
        chk("err_early", 32'(o_cfg_err), 0);
        step();
        chk("err_pulse", 32'(o_cfg_err), 1);
        chk("err_no_pend", 32'(o_pending), 0);
        step();
        chk("err_single", 32'(o_cfg_err), 0);
        frame_edge(0, 1'b1);
        chk("cb_tl_kept", 32'(o_cb_tl), 50);
        wr(3'd3, 8'd50);

        // Foreground counting over a short frame
        for (int i = 0; i < 1600; i++) begin
            i_de = 1'b1;
            i_fg = (i < 1000);
            step();
        end
        i_de = 1'b0;
        i_fg = 1'b0;
        frame_edge(1000, 1'b1);
        chk("fg_count_hold", 32'(o_fg_count), 1000);

        // Write colliding with the applying frame edge
        commit();
        step();
        chk("pend_for_collide", 32'(o_pending), 1);
        exp_q.push_back(0);
        cfg_wr = 1'b1; cfg_addr = 3'd1; cfg_wdata = 8'd10;
        i_vsync = 1'b1;
        step();
        frames++;
        cfg_wr = 1'b0;
        i_vsync = 1'b0;
        chk("collide_y_tl_old", 32'(o_y_tl), 0);
        chk("collide_pend", 32'(o_pending), 0);
        step();
        frame_edge(0, 1'b1);
        chk("y_tl_no_commit", 32'(o_y_tl), 0);
        commit();
        step();
        frame_edge(0, 1'b1);
        chk("y_tl_committed", 32'(o_y_tl), 10);

        // Out-of-range address
        wr(3'd6, 8'd1);
        chk("bad_addr_err", 32'(o_cfg_err), 1);
        step();
        chk("bad_addr_single", 32'(o_cfg_err), 0);

        // Reset while a set is pending
        wr(3'd0, 8'd200);
        commit();
        step();
        chk("pend_before_rst", 32'(o_pending), 1);
        reset_n = 1'b0;
        #1;
        chk("rst_async_pend", 32'(o_pending), 0);
        chk("rst_async_y_th", 32'(o_y_th), 93);
        frames = 0;
        step();
        reset_n = 1'b1;
        step();
        frame_edge(0, 1'b0);
        chk("post_rst_y_th", 32'(o_y_th), 93);
        chk("post_rst_pend", 32'(o_pending), 0);
        repeat (3) step();
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
